// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter that lets NREQ requesters share one load-enable register; counts completed writes.
// Latency: req sampled at edge k -> reg_en high for cycle k..k+1 -> ack from edge k+1; minimum 3 cycles per write.
// Backpressure: the owner holds ack until it drops req; other requests wait, held level, until IDLE.
module reg_write_arbiter #(
    parameter int NREQ = 4,
    parameter int DW   = 4,
    parameter int IW   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*DW-1:0]   din_bus,
    output logic                 reg_en,
    output logic [DW-1:0]        reg_din,
    output logic [NREQ-1:0]      ack,
    output logic [IW-1:0]        owner,
    output logic                 busy,
    output logic [7:0]           wr_count
);

    typedef enum logic [1:0] {IDLE, WRITE, ACK} state_t;

    state_t          state;
    logic [IW-1:0]   last_grant;
    logic [IW-1:0]   winner;
    logic            found;

    // Scan starts just past the previous owner, so every held request is reached within NREQ grants.
    always_comb begin
        int idx;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = (int'(last_grant) + i) % NREQ;
            if (!found && req[IW'(idx)]) begin
                winner = IW'(idx);
                found  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= IW'(NREQ - 1);
            reg_en     <= 1'b0;
            reg_din    <= '0;
            ack        <= '0;
            owner      <= '0;
            busy       <= 1'b0;
            wr_count   <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        reg_din <= din_bus[int'(winner)*DW +: DW];
                        owner   <= winner;
                        reg_en  <= 1'b1;
                        busy    <= 1'b1;
                        state   <= WRITE;
                    end
                end
                WRITE: begin
                    reg_en   <= 1'b0;
                    ack      <= NREQ'(1) << owner;
                    wr_count <= wr_count + 8'd1;
                    state    <= ACK;
                end
                ACK: begin
                    if (!req[owner]) begin
                        ack        <= '0;
                        busy       <= 1'b0;
                        last_grant <= owner;
                        state      <= IDLE;
                    end
                end
                default: begin
                    reg_en <= 1'b0;
                    ack    <= '0;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule
